// File: rtl/pattern_gen.sv
// Registered video test-pattern source: four selectable patterns, two-cycle
// coordinate-to-colour latency, debounced mode button committed at frame end.
module pattern_gen #(
  parameter int unsigned HACTIVE         = 1280,
  parameter int unsigned VACTIVE         = 720,
  parameter int unsigned COORD_W         = 11,
  parameter int unsigned BOX_SIZE        = 64,
  parameter int unsigned CHECKER_LOG2    = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic               pix_clk,
  input  logic               reset,
  input  logic               mode_btn,
  input  logic [COORD_W-1:0] row,
  input  logic [COORD_W-1:0] column,
  output logic [7:0]         r,
  output logic [7:0]         g,
  output logic [7:0]         b,
  output logic [1:0]         mode
);

  typedef enum logic [1:0] {
    MODE_GRADIENT = 2'd0,
    MODE_BARS     = 2'd1,
    MODE_CHECKER  = 2'd2,
    MODE_BOX      = 2'd3
  } mode_e;

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]   DEB_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [COORD_W-1:0] H_LAST  = COORD_W'(HACTIVE - 1);
  localparam logic [COORD_W-1:0] V_LAST  = COORD_W'(VACTIVE - 1);
  localparam logic [COORD_W-1:0] BX_MAX  = COORD_W'(HACTIVE - BOX_SIZE);
  localparam logic [COORD_W-1:0] BY_MAX  = COORD_W'(VACTIVE - BOX_SIZE);
  localparam int unsigned        BAR_W   = HACTIVE / 8;

  logic             sync1_q, sync2_q;
  logic             deb_q, deb_d;
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  mode_e            pending_q, pending_d;
  mode_e            mode_q, mode_d;
  logic [COORD_W-1:0] bx_q, bx_d, by_q, by_d;
  logic             dx_q, dx_d, dy_q, dy_d;
  logic             act1_q, act1_d;
  logic [23:0]      rgb1_q, rgb1_d;
  logic [23:0]      rgb2_q, rgb2_d;
  logic             frame_tick;
  logic [2:0]       bar;
  logic [COORD_W:0] bx_end, by_end;
  logic             in_box;

  // Returns {direction, position}; direction 1 means moving toward lim.
  function automatic logic [COORD_W:0] bounce(input logic [COORD_W-1:0] pos,
                                               input logic up,
                                               input logic [COORD_W-1:0] lim);
    if (up && pos == lim)
      return {1'b0, pos - COORD_W'(1)};
    else if (!up && pos == '0)
      return {1'b1, pos + COORD_W'(1)};
    else if (up)
      return {1'b1, pos + COORD_W'(1)};
    else
      return {1'b0, pos - COORD_W'(1)};
  endfunction

  assign frame_tick = (row == V_LAST) && (column == H_LAST);

  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = deb_cnt_q;
    pending_d = pending_q;
    if (sync2_q == deb_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DEB_MAX) begin
      deb_d     = sync2_q;
      deb_cnt_d = '0;
      if (sync2_q)
        pending_d = mode_e'(pending_q + 2'd1);
    end else begin
      deb_cnt_d = deb_cnt_q + CNT_W'(1);
    end
  end

  // Mode commit reads the pre-increment pending value, so a press landing on
  // the tick is deferred to the following frame.
  always_comb begin
    mode_d = mode_q;
    bx_d   = bx_q;
    by_d   = by_q;
    dx_d   = dx_q;
    dy_d   = dy_q;
    if (frame_tick) begin
      mode_d       = pending_q;
      {dx_d, bx_d} = bounce(bx_q, dx_q, BX_MAX);
      {dy_d, by_d} = bounce(by_q, dy_q, BY_MAX);
    end
  end

  always_comb begin
    bar = '0;
    for (int unsigned k = 1; k < 8; k++) begin
      if ({1'b0, column} >= (COORD_W + 1)'(k * BAR_W))
        bar = 3'(k);
    end
  end

  assign bx_end = {1'b0, bx_q} + (COORD_W + 1)'(BOX_SIZE);
  assign by_end = {1'b0, by_q} + (COORD_W + 1)'(BOX_SIZE);
  assign in_box = (column >= bx_q) && ({1'b0, column} < bx_end) &&
                  (row >= by_q) && ({1'b0, row} < by_end);

  always_comb begin
    act1_d = (row <= V_LAST) && (column <= H_LAST);
    rgb1_d = '0;
    case (mode_q)
      MODE_GRADIENT: rgb1_d = {row[7:0], column[7:0],
                               8'd255 - {1'b0, row[7:1]} - {1'b0, column[7:1]}};
      MODE_BARS:     rgb1_d = {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
      MODE_CHECKER:  rgb1_d = {24{row[CHECKER_LOG2] ^ column[CHECKER_LOG2]}};
      MODE_BOX:      rgb1_d = in_box ? 24'hFF0000 : 24'h000040;
      default:       rgb1_d = '0;
    endcase
    rgb2_d = act1_q ? rgb1_q : '0;
  end

  always_ff @(posedge pix_clk or negedge reset) begin
    if (!reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      deb_q     <= 1'b0;
      deb_cnt_q <= '0;
      pending_q <= MODE_GRADIENT;
      mode_q    <= MODE_GRADIENT;
      bx_q      <= '0;
      by_q      <= '0;
      dx_q      <= 1'b1;
      dy_q      <= 1'b1;
      act1_q    <= 1'b0;
      rgb1_q    <= '0;
      rgb2_q    <= '0;
    end else begin
      sync1_q   <= mode_btn;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      deb_cnt_q <= deb_cnt_d;
      pending_q <= pending_d;
      mode_q    <= mode_d;
      bx_q      <= bx_d;
      by_q      <= by_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      act1_q    <= act1_d;
      rgb1_q    <= rgb1_d;
      rgb2_q    <= rgb2_d;
    end
  end

  assign r    = rgb2_q[23:16];
  assign g    = rgb2_q[15:8];
  assign b    = rgb2_q[7:0];
  assign mode = mode_q;

endmodule

// File: tb/tb_pattern_gen.sv
// Self-checking bench for pattern_gen: directed steps plus random coordinate
// streams compared against a cycle-level behavioural model.
module tb_pattern_gen;
  localparam int H = 64, V = 32, CW = 11, BOX = 8, CL = 5, D = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          btn = 1'b0;
  logic [CW-1:0] row = '0, col = '0;
  logic [7:0]    r, g, b;
  logic [1:0]    mode;

  int checks = 0;
  int fails  = 0;

  int m_mode, m_pend, m_bx, m_by, m_dx, m_dy, m_deb, m_run, m_h1, m_h2;
  logic [23:0] exp_out, prev_e;

  always #5 clk = ~clk;

  pattern_gen #(
    .HACTIVE(H), .VACTIVE(V), .COORD_W(CW), .BOX_SIZE(BOX),
    .CHECKER_LOG2(CL), .DEBOUNCE_CYCLES(D)
  ) dut (
    .pix_clk(clk), .reset(rst_n), .mode_btn(btn), .row(row), .column(col),
    .r(r), .g(g), .b(b), .mode(mode)
  );

  function automatic logic [23:0] ref_colour(int rr, int cc, int md, int bx, int by);
    if (rr >= V || cc >= H) return 24'h0;
    case (md)
      0: return {8'(rr % 256), 8'(cc % 256),
                 8'((255 - (rr % 256) / 2 - (cc % 256) / 2 + 512) % 256)};
      1: case (cc / (H / 8))
           0: return 24'hFFFFFF;
           1: return 24'hFFFF00;
           2: return 24'h00FFFF;
           3: return 24'h00FF00;
           4: return 24'hFF00FF;
           5: return 24'hFF0000;
           6: return 24'h0000FF;
           default: return 24'h000000;
         endcase
      2: return ((((rr >> CL) ^ (cc >> CL)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
      default: return (cc >= bx && cc < bx + BOX && rr >= by && rr < by + BOX)
                      ? 24'hFF0000 : 24'h000040;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pend = 0; m_bx = 0; m_by = 0; m_dx = 1; m_dy = 1;
    m_deb = 0; m_run = 0; m_h1 = 0; m_h2 = 0;
    exp_out = '0; prev_e = '0;
  endtask

  // One pixel clock: check outputs of the previous edge, drive, advance model.
  task automatic cyc(input int rr, input int cc, input logic bt);
    logic [23:0] e;
    int s;
    @(negedge clk);
    chk("pix_stream", {r, g, b}, exp_out);
    chk("mode_stream", {22'd0, mode}, 24'(m_mode));
    row = CW'(rr); col = CW'(cc); btn = bt;
    e = ref_colour(rr, cc, m_mode, m_bx, m_by);
    @(posedge clk);
    exp_out = prev_e;
    prev_e  = e;
    if (rr == V - 1 && cc == H - 1) begin
      m_mode = m_pend;
      if (m_bx + m_dx < 0 || m_bx + m_dx > H - BOX) m_dx = -m_dx;
      m_bx += m_dx;
      if (m_by + m_dy < 0 || m_by + m_dy > V - BOX) m_dy = -m_dy;
      m_by += m_dy;
    end
    // the raw level reaches the debouncer two edges after it is sampled
    s = m_h2; m_h2 = m_h1; m_h1 = int'(bt);
    if (s != m_deb) begin
      m_run++;
      if (m_run == D + 1) begin
        m_deb = s;
        m_run = 0;
        if (s == 1) m_pend = (m_pend + 1) % 4;
      end
    end else begin
      m_run = 0;
    end
  endtask

  task automatic rnd_cyc(input logic bt);
    int rr, cc;
    rr = int'($urandom_range(0, 39));
    cc = int'($urandom_range(0, 79));
    if (rr == V - 1 && cc == H - 1) cc = 0;
    cyc(rr, cc, bt);
  endtask

  task automatic tick();
    cyc(V - 1, H - 1, 1'b0);
  endtask

  task automatic press();
    repeat (D + 6) rnd_cyc(1'b1);
    repeat (D + 6) rnd_cyc(1'b0);
  endtask

  task automatic pix(input int rr, input int cc, input logic [23:0] expv, input string tag);
    cyc(rr, cc, 1'b0);
    cyc(0, 0, 1'b0);
    #1;
    chk(tag, {r, g, b}, expv);
  endtask

  task automatic chk_mode(input string tag, input int expm);
    #1;
    chk(tag, {22'd0, mode}, 24'(expm));
  endtask

  initial begin
    int guard;
    model_reset();
    #12;
    chk("reset_rgb", {r, g, b}, 24'h0);
    chk("reset_mode", {22'd0, mode}, 24'h0);
    @(posedge clk); #2; rst_n = 1'b1;

    pix(3, 5, 24'h0305FC, "grad_3_5");
    pix(40, 70, 24'h000000, "outside_40_70");
    repeat (50) rnd_cyc(1'b0);

    repeat (5) rnd_cyc(1'b1);
    repeat (20) rnd_cyc(1'b0);
    chk_mode("glitch_ignored", 0);
    repeat (20) rnd_cyc(1'b1);
    repeat (15) rnd_cyc(1'b0);
    chk_mode("mode_wait_tick", 0);
    tick();
    chk_mode("mode_after_tick1", 1);

    pix(0, 0, 24'hFFFFFF, "bar_col0");
    pix(0, 8, 24'hFFFF00, "bar_col8");
    pix(0, 16, 24'h00FFFF, "bar_col16");
    pix(0, 56, 24'h000000, "bar_col56");
    repeat (60) rnd_cyc(1'b0);

    press(); tick();
    chk_mode("mode_after_tick2", 2);
    pix(0, 0, 24'h000000, "chk_0_0");
    pix(0, 32, 24'hFFFFFF, "chk_0_32");
    pix(32, 32, 24'h000000, "chk_32_32");
    repeat (60) rnd_cyc(1'b0);

    press(); tick();
    chk_mode("mode_after_tick3", 3);
    pix(m_by, m_bx, 24'hFF0000, "box_corner");
    pix(m_by, m_bx + BOX, 24'h000040, "box_past_right");
    pix(m_by + BOX - 1, m_bx - 1, 24'h000040, "box_left_of");
    repeat (53) tick();
    pix(m_by, 56, 24'hFF0000, "bx56_left_edge");
    pix(m_by, 55, 24'h000040, "bx56_outside");
    pix(m_by, 63, 24'hFF0000, "bx56_right_edge");
    tick();
    pix(m_by, 55, 24'hFF0000, "bx55_left_edge");
    pix(m_by, 63, 24'h000040, "bx55_vacated");
    repeat (40) rnd_cyc(1'b0);

    press(); tick();
    chk_mode("mode_after_tick4", 0);

    repeat (D + 2) rnd_cyc(1'b1);
    cyc(V - 1, H - 1, 1'b1);
    chk_mode("press_on_tick_held", 0);
    repeat (D + 6) rnd_cyc(1'b0);
    tick();
    chk_mode("press_on_tick_next", 1);

    press(); press(); tick();
    chk_mode("mode3_before_reset", 3);
    guard = 0;
    while (m_bx != 20 && guard < 300) begin
      tick();
      guard++;
    end
    chk("reach_bx20", 24'(guard < 300), 24'h1);
    repeat (10) rnd_cyc(1'b0);

    @(posedge clk); #2; rst_n = 1'b0;
    #1;
    chk("midreset_rgb", {r, g, b}, 24'h0);
    chk("midreset_mode", {22'd0, mode}, 24'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #2; rst_n = 1'b1;

    press(); press(); press(); tick();
    chk_mode("post_reset_mode3", 3);
    pix(1, 1, 24'hFF0000, "post_reset_box_1_1");
    pix(0, 1, 24'h000040, "post_reset_row0");
    pix(1, 8, 24'hFF0000, "post_reset_box_1_8");
    pix(1, 9, 24'h000040, "post_reset_col9");
    tick();
    pix(2, 2, 24'hFF0000, "post_reset_box_2_2");
    pix(2, 1, 24'h000040, "post_reset_col1");
    repeat (40) rnd_cyc(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
